jug_threshold: RTL and testbench
================================

JUG_THRESHOLD -- requirements
Module: jug_threshold

Interface
REQ-001 SHALL have parameter CHN_NUM, default 4, number of judged channels (1..16).
REQ-002 SHALL have parameter DATA_W, default 16, unsigned sample width.
REQ-003 SHALL have parameter DBC_W, default 8, confirmation-counter width.
REQ-004 SHALL have port clk_sys, input, 1, system clock; one clock only.
REQ-005 SHALL have port rst_sys, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port chn_dgd_en, input, CHN_NUM, per-channel judge enable.
REQ-007 SHALL have port sample_vld, input, 1, strobe qualifying all jug_data lanes this cycle.
REQ-008 SHALL have port jug_mode, input, 2*CHN_NUM, per-channel mode: 00 less-than, 01 greater-than, 10 outside-window, 11 off.
REQ-009 SHALL have port jug_data, input, CHN_NUM*DATA_W, channel samples, channel 0 in the LSBs.
REQ-010 SHALL have port jug_datastd0, input, CHN_NUM*DATA_W, per-channel low threshold.
REQ-011 SHALL have port jug_datastd1, input, CHN_NUM*DATA_W, per-channel high threshold.
REQ-012 SHALL have port jug_dbc_num, input, DBC_W, consecutive valid samples needed to change state.
REQ-013 SHALL have port jug_raw, output, CHN_NUM, registered instantaneous condition.
REQ-014 SHALL have port jug_result, output, CHN_NUM, debounced fault flag.

Function
REQ-015 Raw condition SHALL be: mode 00 data<std0; 01 data>std1; 10 data<std0 OR data>std1; 11 false; all unsigned, strict.
REQ-016 jug_raw SHALL update only on sample_vld=1 and hold otherwise; 1-cycle latency.
REQ-017 Each channel SHALL run FSM IDLE, PEND, FAULT, RECOV with a DBC_W-bit counter.
REQ-018 IDLE: valid sample with condition true -> PEND, cnt=1; else stay.
REQ-019 PEND: valid true -> cnt+1; on reaching jug_dbc_num -> FAULT; valid false -> IDLE, cnt=0.
REQ-020 FAULT: valid recovery-true -> RECOV, cnt=1; else stay.
REQ-021 RECOV: valid recovery-true -> cnt+1; on reaching jug_dbc_num -> IDLE; valid fault-true -> FAULT, cnt=0.
REQ-022 jug_dbc_num of 0 SHALL behave as 1; transition then occurs on the first qualifying sample.
REQ-023 Counter SHALL saturate, never wrap.
REQ-024 jug_result SHALL be 1 exactly in FAULT and RECOV; asserts the cycle after the Nth qualifying sample edge.
REQ-025 Cycles with sample_vld=0 SHALL neither advance nor clear any counter.
REQ-026 chn_dgd_en=0 or mode 11 SHALL force that channel to IDLE, cnt=0, jug_raw=0, jug_result=0 on the next edge, overriding samples.
REQ-027 Mode or threshold changes SHALL take effect on the next valid sample without clearing state.
REQ-028 std0>std1 in mode 10 SHALL be evaluated literally, no error flag.

Reset
REQ-029 rst_sys=1 at a clk_sys edge SHALL set all FSMs IDLE, counters 0, jug_raw=0, jug_result=0, regardless of sample_vld.
REQ-030 Reset mid-debounce SHALL discard partial counts; no state survives reset.

Configuration
REQ-031 Macro JUG_HYST_EN SHALL, when defined, add input jug_hyst (CHN_NUM*DATA_W) and define recovery-true as: mode 00 data>=std0+hyst; 01 data+hyst<=std1; 10 both; sums in DATA_W+1 bits.
REQ-032 Without JUG_HYST_EN, port jug_hyst SHALL be absent and recovery-true SHALL equal NOT raw condition.

Structure
REQ-033 Package jug_pkg SHALL hold mode encodings (JUG_MODE_LT/GT/WIN/OFF) and FSM state encodings.
REQ-034 Per-channel logic SHALL be sub-module jug_chn, generated CHN_NUM times; top does slicing only.

Verification
REQ-035 Mode 00, std0=100, dbc=3, data 99 on 3 valid samples -> jug_result 1 one cycle after third; data=100 never faults.
REQ-036 Mode 01, std1=500, dbc=4, data 501,501,400,501 -> jug_result stays 0 (PEND cleared).
REQ-037 In FAULT, sample_vld low 10 cycles then chn_dgd_en=0 -> result 0 next edge, FSM IDLE.
REQ-038 Mode 10, std0=10, std1=20, dbc=0, single valid data=25 -> result 1 next cycle; data 15 once -> result 0.
REQ-039 JUG_HYST_EN, mode 00, std0=100, hyst=5, dbc=2 faulted: data 102,102 -> stays FAULT; 105,105 -> IDLE.
REQ-040 rst_sys asserted with PEND cnt=2 of 3 -> after release one further true sample leaves result 0.

Source files
------------

// File: rtl/jug_pkg.sv
// jug_pkg: mode and FSM state encodings shared by the threshold judge.
package jug_pkg;
  localparam logic [1:0] JUG_MODE_LT  = 2'b00;
  localparam logic [1:0] JUG_MODE_GT  = 2'b01;
  localparam logic [1:0] JUG_MODE_WIN = 2'b10;
  localparam logic [1:0] JUG_MODE_OFF = 2'b11;
  localparam logic [1:0] JUG_ST_IDLE  = 2'b00;
  localparam logic [1:0] JUG_ST_PEND  = 2'b01;
  localparam logic [1:0] JUG_ST_FAULT = 2'b10;
  localparam logic [1:0] JUG_ST_RECOV = 2'b11;
endpackage

// File: rtl/jug_threshold_if.sv
// jug_threshold_if: sample/threshold bus of the judge; jug_hyst exists only with JUG_HYST_EN.
interface jug_threshold_if #(
  parameter int CHN_NUM = 4,
  parameter int DATA_W  = 16,
  parameter int DBC_W   = 8
);
  logic [CHN_NUM-1:0]        chn_dgd_en;
  logic                      sample_vld;
  logic [2*CHN_NUM-1:0]      jug_mode;
  logic [CHN_NUM*DATA_W-1:0] jug_data;
  logic [CHN_NUM*DATA_W-1:0] jug_datastd0;
  logic [CHN_NUM*DATA_W-1:0] jug_datastd1;
`ifdef JUG_HYST_EN
  logic [CHN_NUM*DATA_W-1:0] jug_hyst;
`endif
  logic [DBC_W-1:0]          jug_dbc_num;
  logic [CHN_NUM-1:0]        jug_raw;
  logic [CHN_NUM-1:0]        jug_result;
  modport master (
`ifdef JUG_HYST_EN
    output jug_hyst,
`endif
    output chn_dgd_en, sample_vld, jug_mode, jug_data, jug_datastd0, jug_datastd1, jug_dbc_num,
    input  jug_raw, jug_result
  );
  modport slave (
`ifdef JUG_HYST_EN
    input  jug_hyst,
`endif
    input  chn_dgd_en, sample_vld, jug_mode, jug_data, jug_datastd0, jug_datastd1, jug_dbc_num,
    output jug_raw, jug_result
  );
endinterface

// File: rtl/jug_chn.sv
// jug_chn: one channel's condition evaluation and debounce FSM.
// Recovery uses a hysteresis offset when JUG_HYST_EN is defined, else it is NOT the raw condition.
module jug_chn
  import jug_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DBC_W  = 8
) (
  input  logic              clk_sys,
  input  logic              rst_sys,
  input  logic              en,
  input  logic              vld,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] std0,
  input  logic [DATA_W-1:0] std1,
`ifdef JUG_HYST_EN
  input  logic [DATA_W-1:0] hyst,
`endif
  input  logic [DBC_W-1:0]  dbc,
  output logic              raw,
  output logic              result
);
  logic [1:0]       st, st_n;
  logic [DBC_W-1:0] cnt, cnt_n, cnt_inc, dbc_eff;
  logic             lt, gt, cond, rec, act, hit;
  assign lt   = data < std0;
  assign gt   = data > std1;
  assign cond = mode == JUG_MODE_LT  ? lt :
                mode == JUG_MODE_GT  ? gt :
                mode == JUG_MODE_WIN ? (lt | gt) : 1'b0;
`ifdef JUG_HYST_EN
  logic lt_rec, gt_rec;
  assign lt_rec = {1'b0, data} >= {1'b0, std0} + {1'b0, hyst};
  assign gt_rec = {1'b0, data} + {1'b0, hyst} <= {1'b0, std1};
  assign rec    = mode == JUG_MODE_LT  ? lt_rec :
                  mode == JUG_MODE_GT  ? gt_rec :
                  mode == JUG_MODE_WIN ? (lt_rec & gt_rec) : 1'b0;
`else
  assign rec = ~cond;
`endif
  assign act     = en && mode != JUG_MODE_OFF;
  assign dbc_eff = dbc == '0 ? DBC_W'(1) : dbc;
  assign cnt_inc = &cnt ? cnt : cnt + DBC_W'(1);
  // cnt is 0 in IDLE/FAULT, so cnt_inc covers both the first and later qualifying samples
  assign hit     = cnt_inc >= dbc_eff;
  assign result  = st == JUG_ST_FAULT || st == JUG_ST_RECOV;
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    if (vld)
      case (st)
        JUG_ST_IDLE, JUG_ST_PEND: begin
          st_n  = cond ? (hit ? JUG_ST_FAULT : JUG_ST_PEND) : JUG_ST_IDLE;
          cnt_n = cond && !hit ? cnt_inc : '0;
        end
        default: begin
          if (rec) begin
            st_n  = hit ? JUG_ST_IDLE : JUG_ST_RECOV;
            cnt_n = hit ? '0 : cnt_inc;
          end else if (cond) begin
            st_n  = JUG_ST_FAULT;
            cnt_n = '0;
          end
        end
      endcase
  end
  always_ff @(posedge clk_sys) begin
    if (rst_sys || !act) begin
      st  <= JUG_ST_IDLE;
      cnt <= '0;
      raw <= 1'b0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
      if (vld) raw <= cond;
    end
  end
endmodule

// File: rtl/jug_threshold.sv
// jug_threshold: slices the bus into CHN_NUM independent jug_chn judges (JUG_HYST_EN adds hysteresis).
module jug_threshold
  import jug_pkg::*;
#(
  parameter int CHN_NUM = 4,
  parameter int DATA_W  = 16,
  parameter int DBC_W   = 8
) (
  input logic           clk_sys,
  input logic           rst_sys,
  jug_threshold_if.slave bus
);
  for (genvar c = 0; c < CHN_NUM; c++) begin : g_chn
    jug_chn #(.DATA_W(DATA_W), .DBC_W(DBC_W)) u_chn (
      .clk_sys(clk_sys),
      .rst_sys(rst_sys),
      .en     (bus.chn_dgd_en[c]),
      .vld    (bus.sample_vld),
      .mode   (bus.jug_mode[2*c +: 2]),
      .data   (bus.jug_data[c*DATA_W +: DATA_W]),
      .std0   (bus.jug_datastd0[c*DATA_W +: DATA_W]),
      .std1   (bus.jug_datastd1[c*DATA_W +: DATA_W]),
`ifdef JUG_HYST_EN
      .hyst   (bus.jug_hyst[c*DATA_W +: DATA_W]),
`endif
      .dbc    (bus.jug_dbc_num),
      .raw    (bus.jug_raw[c]),
      .result (bus.jug_result[c])
    );
  end
endmodule

// File: tb/tb_jug_threshold.sv
// tb_jug_threshold: directed scoreboard bench on channel 0; channels 1..3 sit in mode off and must stay 0.
module tb_jug_threshold;
  logic clk_sys = 1'b0;
  logic rst_sys;
  int   total = 0;
  int   bad = 0;
  typedef struct {
    logic  r;
    logic  s;
    string tag;
  } exp_t;
  exp_t q[$];
  always #5 clk_sys = ~clk_sys;
  jug_threshold_if #(.CHN_NUM(4), .DATA_W(16), .DBC_W(8)) bus ();
  jug_threshold #(.CHN_NUM(4), .DATA_W(16), .DBC_W(8)) dut (
    .clk_sys(clk_sys),
    .rst_sys(rst_sys),
    .bus    (bus)
  );
  task automatic cyc(input logic v, input logic [15:0] d, input logic er, input logic es, input string tag);
    exp_t e;
    bus.sample_vld = v;
    bus.jug_data[15:0] = d;
    q.push_back('{er, es, tag});
    @(posedge clk_sys);
    #1;
    e = q.pop_front();
    total++;
    assert (bus.jug_raw === {3'b000, e.r})
    else begin
      bad++;
      $error("FAIL %s raw got=%b want=%b", e.tag, bus.jug_raw, {3'b000, e.r});
    end
    total++;
    assert (bus.jug_result === {3'b000, e.s})
    else begin
      bad++;
      $error("FAIL %s result got=%b want=%b", e.tag, bus.jug_result, {3'b000, e.s});
    end
  endtask
  initial begin
    rst_sys = 1'b1;
    bus.chn_dgd_en = 4'b1111;
    bus.sample_vld = 1'b0;
    bus.jug_mode = 8'b11111100;
    bus.jug_data = '0;
    bus.jug_datastd0 = '0;
    bus.jug_datastd1 = '0;
`ifdef JUG_HYST_EN
    bus.jug_hyst = '0;
`endif
    bus.jug_dbc_num = 8'd3;
    bus.jug_datastd0[15:0] = 16'd100;
    cyc(1, 16'd99, 0, 0, "rst_a");
    cyc(1, 16'd99, 0, 0, "rst_b");
    rst_sys = 1'b0;
    cyc(1, 16'd99, 1, 0, "lt_s1");
    cyc(0, 16'd200, 1, 0, "lt_hold");
    cyc(1, 16'd99, 1, 0, "lt_s2");
    cyc(1, 16'd99, 1, 1, "lt_s3");
    cyc(1, 16'd100, 0, 1, "lt_rec1");
    cyc(1, 16'd100, 0, 1, "lt_rec2");
    cyc(1, 16'd100, 0, 0, "lt_rec3");
    cyc(1, 16'd100, 0, 0, "lt_eq_a");
    cyc(1, 16'd100, 0, 0, "lt_eq_b");
    bus.jug_mode[1:0] = 2'b01;
    bus.jug_datastd1[15:0] = 16'd500;
    bus.jug_dbc_num = 8'd4;
    cyc(1, 16'd501, 1, 0, "gt_1");
    cyc(1, 16'd501, 1, 0, "gt_2");
    cyc(1, 16'd400, 0, 0, "gt_clr");
    cyc(1, 16'd501, 1, 0, "gt_4");
    cyc(1, 16'd501, 1, 0, "gt_5");
    cyc(1, 16'd501, 1, 0, "gt_6");
    cyc(1, 16'd501, 1, 1, "gt_7");
    for (int i = 0; i < 10; i++) cyc(0, 16'd400, 1, 1, "gt_idle");
    bus.chn_dgd_en[0] = 1'b0;
    cyc(0, 16'd501, 0, 0, "dis");
    bus.chn_dgd_en[0] = 1'b1;
    cyc(1, 16'd501, 1, 0, "dis_idle");
    cyc(1, 16'd400, 0, 0, "gt_back");
    bus.jug_mode[1:0] = 2'b10;
    bus.jug_datastd0[15:0] = 16'd10;
    bus.jug_datastd1[15:0] = 16'd20;
    bus.jug_dbc_num = 8'd0;
    cyc(1, 16'd25, 1, 1, "win_hi");
    cyc(1, 16'd15, 0, 0, "win_in");
    cyc(1, 16'd5, 1, 1, "win_lo");
    cyc(1, 16'd20, 0, 0, "win_edge");
    bus.jug_datastd0[15:0] = 16'd30;
    cyc(1, 16'd25, 1, 1, "win_inv");
    bus.jug_datastd0[15:0] = 16'd10;
    cyc(1, 16'd15, 0, 0, "win_thr");
    bus.jug_mode[1:0] = 2'b00;
    bus.jug_datastd0[15:0] = 16'd100;
    bus.jug_dbc_num = 8'd255;
    for (int i = 1; i <= 255; i++) cyc(1, 16'd99, 1, logic'(i == 255), "dbc_max");
    bus.chn_dgd_en[0] = 1'b0;
    cyc(0, 16'd0, 0, 0, "dis2");
    bus.chn_dgd_en[0] = 1'b1;
`ifdef JUG_HYST_EN
    bus.jug_dbc_num = 8'd2;
    bus.jug_hyst[15:0] = 16'd5;
    cyc(1, 16'd99, 1, 0, "hy_1");
    cyc(1, 16'd99, 1, 1, "hy_2");
    cyc(1, 16'd102, 0, 1, "hy_band1");
    cyc(1, 16'd102, 0, 1, "hy_band2");
    cyc(1, 16'd105, 0, 1, "hy_rec1");
    cyc(1, 16'd105, 0, 0, "hy_rec2");
    bus.jug_hyst[15:0] = 16'd0;
`endif
    bus.jug_dbc_num = 8'd3;
    cyc(1, 16'd99, 1, 0, "rp_1");
    cyc(1, 16'd99, 1, 0, "rp_2");
    rst_sys = 1'b1;
    cyc(1, 16'd99, 0, 0, "rp_rst");
    rst_sys = 1'b0;
    cyc(1, 16'd99, 1, 0, "rp_a");
    cyc(1, 16'd99, 1, 0, "rp_b");
    bus.jug_mode[1:0] = 2'b11;
    cyc(1, 16'd99, 0, 0, "off");
    bus.jug_mode[1:0] = 2'b00;
    cyc(1, 16'd99, 1, 0, "off_a");
    cyc(1, 16'd99, 1, 0, "off_b");
    cyc(1, 16'd99, 1, 1, "off_c");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
